// File: rtl/elevator_controller.sv
// SCAN dispatcher for the elevator car: latches floor calls, steps the car one floor per cycle,
// holds the door open at served floors and freezes on an out-of-range floor report.
module elevator_controller #(
  parameter int NUM_FLOORS  = 5,
  parameter int FLOOR_W     = 5,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [NUM_FLOORS-1:0] CallReq,
  input  logic [FLOOR_W-1:0]    WhichFloor,
  output logic [1:0]            State,
  output logic                  DoorOpen,
  output logic                  DirUp,
  output logic [NUM_FLOORS-1:0] PendingCalls,
  output logic                  Fault
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b11;
  localparam logic [1:0] CMD_DOWN = 2'b01;

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} FsmState;

  FsmState               r_fsm, w_nextFsm;
  logic [1:0]            r_state, w_nextState;
  logic                  r_doorOpen, w_nextDoor;
  logic                  r_dirUp, w_nextDir;
  logic [NUM_FLOORS-1:0] r_pending, w_nextPending;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_dwell, w_nextDwell;

  logic                  w_floorOk, w_freeze;
  logic [NUM_FLOORS-1:0] w_floorBit, w_latched, w_visible;
  logic                  w_above, w_below, w_here, w_atTop, w_atBottom;

  // While dwelling, the served floor's call is masked so it can never reopen the door.
  always_comb begin
    w_floorOk  = (WhichFloor < FLOOR_W'(NUM_FLOORS));
    w_freeze   = r_fault || !w_floorOk;
    w_floorBit = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (WhichFloor == FLOOR_W'(i)) w_floorBit[i] = 1'b1;
    end
    w_latched = r_pending | CallReq;
    w_visible = (r_fsm == DOOR) ? (w_latched & ~w_floorBit) : w_latched;
    w_above   = 1'b0;
    w_below   = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_visible[i] && (FLOOR_W'(i) > WhichFloor)) w_above = 1'b1;
      if (w_visible[i] && (FLOOR_W'(i) < WhichFloor)) w_below = 1'b1;
    end
    w_here     = |(w_visible & w_floorBit);
    w_atTop    = (WhichFloor == FLOOR_W'(NUM_FLOORS - 1));
    w_atBottom = (WhichFloor == '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fsm      <= IDLE;
      r_state    <= CMD_STOP;
      r_doorOpen <= 1'b0;
      r_dirUp    <= 1'b1;
      r_pending  <= '0;
      r_fault    <= 1'b0;
      r_dwell    <= '0;
    end else begin
      r_fsm      <= w_nextFsm;
      r_state    <= w_nextState;
      r_doorOpen <= w_nextDoor;
      r_dirUp    <= w_nextDir;
      r_pending  <= w_nextPending;
      r_fault    <= r_fault | !w_floorOk;
      r_dwell    <= w_nextDwell;
    end
  end

  always_comb begin
    w_nextFsm   = r_fsm;
    w_nextDir   = r_dirUp;
    w_nextDwell = r_dwell;
    if (w_freeze) begin
      w_nextFsm   = IDLE;
      w_nextDwell = '0;
    end else begin
      case (r_fsm)
        UP: begin
          if (w_here) begin
            w_nextFsm   = DOOR;
            w_nextDwell = '0;
          end else if (!w_above || w_atTop) begin
            w_nextFsm = IDLE;
          end
        end
        DOWN: begin
          if (w_here) begin
            w_nextFsm   = DOOR;
            w_nextDwell = '0;
          end else if (!w_below || w_atBottom) begin
            w_nextFsm = IDLE;
          end
        end
        default: begin
          // IDLE, and DOOR once the dwell expires, share the SCAN decision.
          if ((r_fsm == DOOR) && (r_dwell != CNT_W'(DOOR_CYCLES - 1))) begin
            w_nextDwell = r_dwell + 1'b1;
          end else if (w_here) begin
            w_nextFsm   = DOOR;
            w_nextDwell = '0;
          end else if (w_above && (r_dirUp || !w_below)) begin
            w_nextFsm = UP;
            w_nextDir = 1'b1;
          end else if (w_below) begin
            w_nextFsm = DOWN;
            w_nextDir = 1'b0;
          end else begin
            w_nextFsm = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_nextState = CMD_STOP;
    w_nextDoor  = 1'b0;
    case (w_nextFsm)
      UP:      w_nextState = w_atTop ? CMD_STOP : CMD_UP;
      DOWN:    w_nextState = w_atBottom ? CMD_STOP : CMD_DOWN;
      DOOR:    w_nextDoor  = 1'b1;
      default: w_nextState = CMD_STOP;
    endcase
    if (w_freeze) begin
      w_nextPending = r_pending;
    end else if (w_nextFsm == DOOR) begin
      w_nextPending = w_visible & ~w_floorBit;
    end else begin
      w_nextPending = w_visible;
    end
  end

  assign State        = r_state;
  assign DoorOpen     = r_doorOpen;
  assign DirUp        = r_dirUp;
  assign PendingCalls = r_pending;
  assign Fault        = r_fault;

endmodule
